// File: rtl/sd_spi_pkg.sv
// rtl/sd_spi_pkg.sv - shared types and constants for the SD SPI master
package sd_spi_pkg;

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  localparam logic [7:0] SPI_FILL  = 8'hFF;
  localparam int         DIV_W_DEF = 8;

endpackage

// File: rtl/sd_spi_master_if.sv
// rtl/sd_spi_master_if.sv - byte stream interface to the SPI master; poll signals with SD_SPI_AUTOPOLL_EN
interface sd_spi_master_if;

  logic       fast;
  logic       cs_req;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
`ifdef SD_SPI_AUTOPOLL_EN
  logic       poll_req;
  logic       poll_timeout;

  modport master (output fast, cs_req, tx_data, tx_valid, poll_req,
                  input  tx_ready, rx_data, rx_valid, busy, poll_timeout);
  modport slave  (input  fast, cs_req, tx_data, tx_valid, poll_req,
                  output tx_ready, rx_data, rx_valid, busy, poll_timeout);
`else
  modport master (output fast, cs_req, tx_data, tx_valid,
                  input  tx_ready, rx_data, rx_valid, busy);
  modport slave  (input  fast, cs_req, tx_data, tx_valid,
                  output tx_ready, rx_data, rx_valid, busy);
`endif

endinterface

// File: rtl/sd_spi_clkgen.sv
// rtl/sd_spi_clkgen.sv - sck half-period counter with a divider latched at byte start
module sd_spi_clkgen
  import sd_spi_pkg::*;
#(
  parameter int CLK_DIV_SLOW = 64,
  parameter int CLK_DIV_FAST = 2,
  parameter int DIV_W        = DIV_W_DEF
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic start,
  input  logic fast,
  input  logic run,
  output logic tick
);

  // Stored as DIV-1 so a divider of exactly 2^DIV_W still fits.
  localparam logic [DIV_W-1:0] SLOW_LAST = DIV_W'(CLK_DIV_SLOW - 1);
  localparam logic [DIV_W-1:0] FAST_LAST = DIV_W'(CLK_DIV_FAST - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_last;

  assign tick = run && (div_cnt == div_last);

  // Restart and latch the rate on byte start, then wrap at the terminal count.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt  <= '0;
      div_last <= '0;
    end else if (start) begin
      div_cnt  <= '0;
      div_last <= fast ? FAST_LAST : SLOW_LAST;
    end else if (tick) begin
      div_cnt  <= '0;
    end else if (run) begin
      div_cnt  <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sd_spi_master.sv
// rtl/sd_spi_master.sv - byte-level SPI mode-0 master; optional card-busy poll with SD_SPI_AUTOPOLL_EN
module sd_spi_master
  import sd_spi_pkg::*;
#(
  parameter int CLK_DIV_SLOW = 64,
  parameter int CLK_DIV_FAST = 2,
  parameter int DIV_W        = DIV_W_DEF,
  parameter int POLL_LIMIT   = 8
) (
  input  logic           clk_sys,
  input  logic           reset_n,
  sd_spi_master_if.slave bus,
  output logic           ss,
  output logic           sck,
  output logic           mosi,
  input  logic           miso
);

  state_t     state;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic [7:0] rx_data_q;
  logic       tx_ready_q;
  logic       rx_valid_q;
  logic       busy_q;
  logic       tick;
  logic       accept;
  logic       poll_start;
  logic       poll_again;
  logic       start;
  logic       byte_end;

  assign bus.tx_ready = tx_ready_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.busy     = busy_q;

  assign accept   = (state == IDLE) && bus.tx_valid && tx_ready_q && !poll_start;
  assign start    = accept || poll_start;
  assign byte_end = (state == HIGH) && tick && (bit_cnt == 3'd7);

  sd_spi_clkgen #(
    .CLK_DIV_SLOW (CLK_DIV_SLOW),
    .CLK_DIV_FAST (CLK_DIV_FAST),
    .DIV_W        (DIV_W)
  ) u_clkgen (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .start   (start),
    .fast    (bus.fast),
    .run     (state != IDLE),
    .tick    (tick)
  );

`ifdef SD_SPI_AUTOPOLL_EN
  localparam int             PCW       = $clog2(POLL_LIMIT + 1);
  localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_LIMIT - 1);

  logic           poll_mode;
  logic           timeout_q;
  logic [PCW-1:0] poll_cnt;

  assign poll_start       = (state == IDLE) && bus.poll_req;
  assign poll_again       = poll_mode && (shreg == SPI_FILL) && (poll_cnt != POLL_LAST);
  assign bus.poll_timeout = timeout_q;

  // Track poll length and flag a poll that never saw anything but fill bytes.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      poll_mode <= 1'b0;
      poll_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (poll_start) begin
        poll_mode <= 1'b1;
        poll_cnt  <= '0;
      end else if (byte_end) begin
        if (poll_again) begin
          poll_cnt  <= poll_cnt + 1'b1;
        end else begin
          timeout_q <= poll_mode && (shreg == SPI_FILL);
          poll_mode <= 1'b0;
        end
      end
    end
  end
`else
  assign poll_start = 1'b0;
  assign poll_again = 1'b0;
`endif

  // Byte framing: sck phases, MSB-first shift, handshake and card select.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ss         <= 1'b1;
      sck        <= 1'b0;
      mosi       <= 1'b1;
      shreg      <= SPI_FILL;
      bit_cnt    <= 3'd0;
      rx_data_q  <= SPI_FILL;
      tx_ready_q <= 1'b1;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          ss <= ~bus.cs_req;
          if (start) begin
            shreg      <= poll_start ? SPI_FILL : bus.tx_data;
            mosi       <= poll_start ? 1'b1 : bus.tx_data[7];
            bit_cnt    <= 3'd0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state      <= LOW;
          end
        end
        LOW: begin
          if (tick) begin
            sck   <= 1'b1;
            shreg <= {shreg[6:0], miso};
            state <= HIGH;
          end
        end
        HIGH: begin
          if (tick) begin
            sck <= 1'b0;
            if (bit_cnt != 3'd7) begin
              bit_cnt <= bit_cnt + 3'd1;
              mosi    <= shreg[7];
              state   <= LOW;
            end else if (poll_again) begin
              // Next poll byte starts with no idle gap.
              shreg   <= SPI_FILL;
              mosi    <= 1'b1;
              bit_cnt <= 3'd0;
              state   <= LOW;
            end else begin
              rx_data_q  <= shreg;
              rx_valid_q <= 1'b1;
              tx_ready_q <= 1'b1;
              busy_q     <= 1'b0;
              mosi       <= 1'b1;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_spi_master.sv
// tb/tb_sd_spi_master.sv - self-checking bench for sd_spi_master against a cycle-arithmetic model
module tb_sd_spi_master;

  localparam int SLOW = 64;
  localparam int FAST = 2;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  logic ss, sck, mosi, miso;

  sd_spi_master_if bus();

  sd_spi_master #(
    .CLK_DIV_SLOW (SLOW),
    .CLK_DIV_FAST (FAST),
    .DIV_W        (8),
    .POLL_LIMIT   (8)
  ) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus),
    .ss      (ss),
    .sck     (sck),
    .mosi    (mosi),
    .miso    (miso)
  );

  always #5 clk_sys = ~clk_sys;

  // Card side: loopback, or a byte stream from resp_arr shifted out per sck rise.
  logic       loop = 1'b1;
  logic [7:0] resp_arr [0:255];
  int         s_cnt = 0;
  int         s_byte = 0;
  logic       s_bit = 1'b1;
  logic       sck_q = 1'b0;

  assign miso = loop ? mosi : s_bit;

  always @(negedge clk_sys) begin
    if (!reset_n) begin
      s_cnt = 0;
      sck_q = 1'b0;
    end else begin
      if (sck === 1'b1 && sck_q === 1'b0) begin
        s_cnt++;
        if (s_cnt == 8) begin
          s_cnt = 0;
          s_byte++;
        end
      end
      sck_q = sck;
    end
    s_bit = resp_arr[s_byte % 256][7 - s_cnt];
  end

  // Reference model: a byte accepted at edge 0 lasts 16*DIV edges; k counts edges since accept.
  logic       m_act = 1'b0;
  int         m_k = 0;
  int         m_div = SLOW;
  int         m_n = 0;
  int         m_acc = 0;
  logic [7:0] m_tx = 8'hFF;
  logic [7:0] m_rx = 8'hFF;
  logic [7:0] m_last = 8'hFF;
  logic       m_ss = 1'b1;

  always @(posedge clk_sys) begin
    if (!reset_n) begin
      m_act  = 1'b0;
      m_k    = 0;
      m_ss   = 1'b1;
      m_last = 8'hFF;
    end else if (!m_act || m_k == 16 * m_div) begin
      m_ss = ~bus.cs_req;
      if (bus.tx_valid) begin
        m_act = 1'b1;
        m_k   = 0;
        m_div = bus.fast ? FAST : SLOW;
        m_tx  = bus.tx_data;
        m_rx  = loop ? bus.tx_data : resp_arr[m_n % 256];
        m_acc++;
      end else begin
        m_act = 1'b0;
      end
    end else begin
      m_k++;
      if (m_k == 16 * m_div) begin
        m_last = m_rx;
        m_n++;
      end
    end
  end

  int   n_vec = 0;
  int   n_err = 0;
  logic chk_en = 1'b1;

  task automatic chk1(string nm, logic a, logic e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %b want %b at %0t", nm, a, e, $time);
    end
  endtask

  task automatic chk8(string nm, logic [7:0] a, logic [7:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic chkn(string nm, int a, int e);
    n_vec++;
    if (a != e) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, a, e, $time);
    end
  endtask

  task automatic compare();
    logic run, done;
    run  = m_act && (m_k < 16 * m_div);
    done = m_act && (m_k == 16 * m_div);
    chk1("ss", ss, m_ss);
    chk1("sck", sck, run ? ((m_k / m_div) % 2 == 1) : 1'b0);
    chk1("mosi", mosi, run ? m_tx[7 - m_k / (2 * m_div)] : 1'b1);
    chk1("busy", bus.busy, run);
    chk1("tx_ready", bus.tx_ready, !run);
    chk1("rx_valid", bus.rx_valid, done);
    chk8("rx_data", bus.rx_data, m_last);
  endtask

  task automatic tick();
    @(negedge clk_sys);
    if (chk_en) compare();
  endtask

  task automatic wait_rx(output int n, output int rises, output logic ss_hi);
    logic prev;
    prev  = sck;
    n     = 0;
    rises = 0;
    ss_hi = 1'b0;
    while (bus.rx_valid !== 1'b1 && n < 5000) begin
      tick();
      n++;
      if (sck === 1'b1 && prev === 1'b0) rises++;
      prev = sck;
      if (ss !== 1'b0) ss_hi = 1'b1;
    end
  endtask

  task automatic run_random(int nbytes);
    int target;
    int guard;
    target = m_acc + nbytes;
    guard  = 0;
    while (m_acc < target && guard < 40000) begin
      bus.tx_valid = ($urandom_range(2) == 0);
      bus.tx_data  = 8'($urandom);
      bus.fast     = ($urandom_range(3) != 0);
      bus.cs_req   = ($urandom_range(1) == 1);
      tick();
      guard++;
    end
    chkn("random_progress", m_acc, target);
    bus.tx_valid = 1'b0;
    guard = 0;
    while (bus.busy !== 1'b0 && guard < 3000) begin
      tick();
      guard++;
    end
    chk1("random_drain", bus.busy, 1'b0);
  endtask

  int   n1, n2, r1, r2;
  logic h1, h2;

  initial begin
    for (int i = 0; i < 256; i++) resp_arr[i] = 8'($urandom);
    bus.fast     = 1'b0;
    bus.cs_req   = 1'b0;
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
`ifdef SD_SPI_AUTOPOLL_EN
    bus.poll_req = 1'b0;
`endif

    // Reset values.
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    chk1("rst_ss", ss, 1'b1);
    chk1("rst_sck", sck, 1'b0);
    chk1("rst_mosi", mosi, 1'b1);
    chk1("rst_tx_ready", bus.tx_ready, 1'b1);
    chk1("rst_rx_valid", bus.rx_valid, 1'b0);
    chk8("rst_rx_data", bus.rx_data, 8'hFF);
    chk1("rst_busy", bus.busy, 1'b0);

    // Slow loopback of A5.
    loop         = 1'b1;
    bus.cs_req   = 1'b1;
    bus.tx_data  = 8'hA5;
    bus.tx_valid = 1'b1;
    tick();
    bus.tx_valid = 1'b0;
    wait_rx(n1, r1, h1);
    chkn("a5_latency", n1, 1024);
    chkn("a5_sck_rises", r1, 8);
    chk1("a5_ss_high_seen", h1, 1'b0);
    chk8("a5_rx", bus.rx_data, 8'hA5);
    chk8("a5_model_rx", m_last, 8'hA5);
    chkn("a5_model_len", 16 * m_div, 1024);

    // Back-to-back at fast rate with tx_valid held.
    bus.fast     = 1'b1;
    bus.tx_data  = 8'h12;
    bus.tx_valid = 1'b1;
    tick();
    bus.tx_data  = 8'h34;
    wait_rx(n1, r1, h1);
    chk8("b2b_rx0", bus.rx_data, 8'h12);
    chkn("b2b_len0", n1, 32);
    tick();
    bus.tx_valid = 1'b0;
    wait_rx(n2, r2, h2);
    chk8("b2b_rx1", bus.rx_data, 8'h34);
    chkn("b2b_total", n1 + 1 + n2, 65);
    chkn("b2b_rises", r1 + r2, 16);

    // Control changes mid-byte are ignored until idle.
    bus.fast     = 1'b0;
    bus.tx_data  = 8'h3C;
    bus.tx_valid = 1'b1;
    tick();
    bus.tx_valid = 1'b0;
    repeat (3 * 2 * SLOW + 10) tick();
    bus.cs_req = 1'b0;
    bus.fast   = 1'b1;
    wait_rx(n1, r1, h1);
    chkn("mid_total", 3 * 2 * SLOW + 10 + n1, 1024);
    chk1("mid_ss_high_seen", h1, 1'b0);
    chk8("mid_rx", bus.rx_data, 8'h3C);
    tick();
    chk1("mid_ss_after", ss, 1'b1);

    // Reset mid-byte aborts with no rx_valid.
    loop         = 1'b0;
    bus.cs_req   = 1'b1;
    bus.fast     = 1'b0;
    bus.tx_data  = 8'h5A;
    bus.tx_valid = 1'b1;
    tick();
    bus.tx_valid = 1'b0;
    repeat (300) tick();
    reset_n = 1'b0;
    tick();
    chk1("abort_ss", ss, 1'b1);
    chk1("abort_rx_valid", bus.rx_valid, 1'b0);
    chk1("abort_busy", bus.busy, 1'b0);
    reset_n = 1'b1;
    tick();

    // Randomized traffic: loopback, then card responses.
    loop = 1'b1;
    run_random(25);
    loop = 1'b0;
    run_random(25);

`ifdef SD_SPI_AUTOPOLL_EN
    // Poll ends on first non-fill byte.
    chk_en   = 1'b0;
    bus.fast = 1'b1;
    resp_arr[(s_byte + 0) % 256] = 8'hFF;
    resp_arr[(s_byte + 1) % 256] = 8'hFF;
    resp_arr[(s_byte + 2) % 256] = 8'hFF;
    resp_arr[(s_byte + 3) % 256] = 8'h00;
    bus.poll_req = 1'b1;
    tick();
    bus.poll_req = 1'b0;
    wait_rx(n1, r1, h1);
    chkn("poll_len", n1, 4 * 32);
    chk8("poll_rx", bus.rx_data, 8'h00);
    chk1("poll_timeout0", bus.poll_timeout, 1'b0);
    tick();
    // Poll gives up after POLL_LIMIT fill bytes.
    for (int i = 0; i < 8; i++) resp_arr[(s_byte + i) % 256] = 8'hFF;
    bus.poll_req = 1'b1;
    tick();
    bus.poll_req = 1'b0;
    wait_rx(n1, r1, h1);
    chkn("poll_to_len", n1, 8 * 32);
    chk8("poll_to_rx", bus.rx_data, 8'hFF);
    chk1("poll_timeout1", bus.poll_timeout, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
